// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg : shared FSM state type and width helper for seq_detect_p
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_HUNT = 2'b11
  } state_t;

  // Width needed to hold a pattern length of 0..pat_w inclusive.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_cnt.sv
// ---------------------------------------------------------------------------
// seq_match_cnt : saturating match counter, clear has priority over increment
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_match_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != {CNT_W{1'b1}})) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_p.sv
// ---------------------------------------------------------------------------
// seq_detect_p : programmable serial pattern detector with match counter.
// Optional SEQ_DETECT_MASK_EN adds a per-bit don't-care mask. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_detect_p
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic                     i_bit,
  input  logic                     i_cfg_load,
  input  logic [PAT_W-1:0]         i_pat,
  input  logic [len_w(PAT_W)-1:0]  i_pat_len,
  input  logic                     i_overlap,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [PAT_W-1:0]         i_pat_mask,
`endif
  input  logic                     i_cnt_clr,
  output logic                     o_match,
  output logic [CNT_W-1:0]         o_match_cnt,
  output logic                     o_armed
);

  localparam int LW = len_w(PAT_W);

  state_t           state;
  // Only the older PAT_W-1 bits are stored; the newest bit is i_bit itself.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] pat;
  logic [LW-1:0]    len;
  logic [LW-1:0]    fill;
  logic             overlap;
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0] mask;
`endif

  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] care;
  logic [LW-1:0]    fill_nxt;
  logic [LW-1:0]    len_in;
  logic             accept;
  logic             hit;

  always_comb begin
    hist_nxt = {hist, i_bit};
    fill_nxt = (fill == len) ? len : fill + LW'(1);
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len));
    end
`ifdef SEQ_DETECT_MASK_EN
    care = len_mask & ~mask;
`else
    care = len_mask;
`endif
    accept = i_valid && (state != ST_IDLE) && !i_cfg_load;
    hit    = accept && (fill_nxt == len) && (((hist_nxt ^ pat) & care) == '0);
    len_in = (i_pat_len > LW'(PAT_W)) ? LW'(PAT_W) : i_pat_len;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      hist    <= '0;
      fill    <= '0;
      pat     <= '0;
      len     <= '0;
      overlap <= 1'b0;
`ifdef SEQ_DETECT_MASK_EN
      mask    <= '0;
`endif
      o_match <= 1'b0;
    end else begin
      o_match <= hit;
      if (i_cfg_load) begin
        pat     <= i_pat;
        len     <= len_in;
        overlap <= i_overlap;
`ifdef SEQ_DETECT_MASK_EN
        mask    <= i_pat_mask;
`endif
        hist    <= '0;
        fill    <= '0;
        state   <= (len_in == '0) ? ST_IDLE : ST_FILL;
      end else if (accept) begin
        hist <= hist_nxt[PAT_W-2:0];
        if (hit && !overlap) begin
          fill  <= '0;
          state <= ST_FILL;
        end else begin
          fill  <= fill_nxt;
          state <= (fill_nxt == len) ? ST_HUNT : ST_FILL;
        end
      end
    end
  end

  assign o_armed = (state != ST_IDLE);

  seq_match_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cnt_clr),
    .i_inc   (hit),
    .o_cnt   (o_match_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_p.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_p : directed + random bench for seq_detect_p (two counter widths)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_detect_p;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, bitv, cfg_load, overlap, cnt_clr;
  logic [7:0]  pat, mask;
  logic [3:0]  pat_len;
  logic        match_a, armed_a, match_b, armed_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  seq_detect_p #(.PAT_W(8), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_bit(bitv),
    .i_cfg_load(cfg_load), .i_pat(pat), .i_pat_len(pat_len), .i_overlap(overlap),
`ifdef SEQ_DETECT_MASK_EN
    .i_pat_mask(mask),
`endif
    .i_cnt_clr(cnt_clr), .o_match(match_a), .o_match_cnt(cnt_a), .o_armed(armed_a)
  );

  seq_detect_p #(.PAT_W(8), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_bit(bitv),
    .i_cfg_load(cfg_load), .i_pat(pat), .i_pat_len(pat_len), .i_overlap(overlap),
`ifdef SEQ_DETECT_MASK_EN
    .i_pat_mask(mask),
`endif
    .i_cnt_clr(cnt_clr), .o_match(match_b), .o_match_cnt(cnt_b), .o_armed(armed_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: bits accepted since the last restart, compared newest-first.
  bit         mq[$];
  int         m_len;
  logic [7:0] m_pat, m_mask;
  bit         m_ov, m_armed, exp_match;
  int         m_cnt_a, m_cnt_b;

  task automatic model_edge();
    bit hit;
    hit = 1'b0;
    exp_match = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_len = 0; m_pat = '0; m_mask = '0; m_ov = 1'b0; m_armed = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0;
      return;
    end
    if (cfg_load) begin
      m_len = (int'(pat_len) > 8) ? 8 : int'(pat_len);
      m_pat = pat;
`ifdef SEQ_DETECT_MASK_EN
      m_mask = mask;
`else
      m_mask = '0;
`endif
      m_ov = overlap;
      mq.delete();
      m_armed = (m_len != 0);
    end else if (valid && m_armed) begin
      mq.push_back(bitv);
      if (mq.size() > 8) void'(mq.pop_front());
      if (mq.size() >= m_len) begin
        hit = 1'b1;
        for (int j = 0; j < m_len; j++)
          if (!m_mask[j] && (mq[mq.size() - 1 - j] != m_pat[j])) hit = 1'b0;
      end
      if (hit && !m_ov) mq.delete();
    end
    exp_match = hit;
    if (cnt_clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (hit) begin
      m_cnt_a = (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
      m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
    end
  endtask

  task automatic check(input string tag);
    tests++; assert (match_a === exp_match) else begin fails++;
      $error("FAIL %s match_a observed=%0b expected=%0b", tag, match_a, exp_match); end
    tests++; assert (armed_a === m_armed) else begin fails++;
      $error("FAIL %s armed_a observed=%0b expected=%0b", tag, armed_a, m_armed); end
    tests++; assert (cnt_a === 16'(m_cnt_a)) else begin fails++;
      $error("FAIL %s cnt_a observed=%0d expected=%0d", tag, cnt_a, m_cnt_a); end
    tests++; assert (match_b === exp_match) else begin fails++;
      $error("FAIL %s match_b observed=%0b expected=%0b", tag, match_b, exp_match); end
    tests++; assert (armed_b === m_armed) else begin fails++;
      $error("FAIL %s armed_b observed=%0b expected=%0b", tag, armed_b, m_armed); end
    tests++; assert (cnt_b === 2'(m_cnt_b)) else begin fails++;
      $error("FAIL %s cnt_b observed=%0d expected=%0d", tag, cnt_b, m_cnt_b); end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); end
  endtask

  task automatic cyc(input logic rn, input logic ld, input logic v, input logic b, input logic cl);
    rst_n = rn; cfg_load = ld; valid = v; bitv = b; cnt_clr = cl;
    @(posedge clk);
    #1;
    model_edge();
    check("step");
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov,
                      input logic [7:0] mk, input logic v, input logic b);
    pat = p; pat_len = l; overlap = ov; mask = mk;
    cyc(1'b1, 1'b1, v, b, 1'b0);
  endtask

  task automatic send(input logic b);
    cyc(1'b1, 1'b0, 1'b1, b, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [7:0] p;
    logic [4:0] s5;
    rst_n = 1'b0; valid = 1'b0; bitv = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    overlap = 1'b0; pat = '0; mask = '0; pat_len = '0;

    // Reset, including a coincident load that must lose
    pat = 8'h05; pat_len = 4'd3; overlap = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("rst_armed", int'(armed_a), 0);
    check_val("rst_cnt", int'(cnt_a), 0);

    // Overlapping 101 over 1,0,1,0,1
    load(8'b101, 4'd3, 1'b1, 8'h00, 1'b0, 1'b0);
    pulses = 0; s5 = 5'b10101;
    for (int i = 4; i >= 0; i--) begin send(s5[i]); if (match_a) pulses++; end
    check_val("ovl_pulses", pulses, 2);
    check_val("ovl_cnt", int'(cnt_a), 2);

    // Non-overlapping, same stream
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    load(8'b101, 4'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 4; i >= 0; i--) begin send(s5[i]); if (match_a) pulses++; end
    check_val("novl_pulses", pulses, 1);
    check_val("novl_cnt", int'(cnt_a), 1);

    // len=8, A5 with idle gaps
    load(8'hA5, 4'd8, 1'b0, 8'h00, 1'b0, 1'b0);
    pulses = 0; p = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      send(p[i]);
      if (match_a) pulses++;
      if (i == 0) check_val("a5_pulse_next", int'(match_a), 1);
      else begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); if (match_a) pulses++; end
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (match_a) pulses++;
    check_val("a5_pulses", pulses, 1);

    // Counter saturation on the 2-bit instance, then clear beside a match
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    load(8'h01, 4'd1, 1'b1, 8'h00, 1'b0, 1'b0);
    send(1'b1); check_val("sat1", int'(cnt_b), 1);
    send(1'b1); check_val("sat2", int'(cnt_b), 2);
    send(1'b1); check_val("sat3", int'(cnt_b), 3);
    send(1'b1); check_val("sat4", int'(cnt_b), 3);
    send(1'b1); check_val("sat5", int'(cnt_b), 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check_val("clr_cnt", int'(cnt_b), 0);
    check_val("clr_match", int'(match_b), 1);

    // Load coincident with the completing bit drops the bit
    load(8'b101, 4'd3, 1'b1, 8'h00, 1'b0, 1'b0);
    send(1'b1); send(1'b0);
    load(8'b101, 4'd3, 1'b1, 8'h00, 1'b1, 1'b1);
    check_val("ld_drop_match", int'(match_a), 0);
    check_val("ld_drop_armed", int'(armed_a), 1);
    send(1'b1); send(1'b0); send(1'b1);
    check_val("ld_refill_match", int'(match_a), 1);

    // Reset mid-sequence, then bits ignored until reload
    send(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("mid_rst_armed", int'(armed_a), 0);
    send(1'b1); send(1'b0); send(1'b1);
    check_val("idle_match", int'(match_a), 0);
    check_val("idle_cnt", int'(cnt_a), 0);

`ifdef SEQ_DETECT_MASK_EN
    load(8'b1001, 4'd4, 1'b1, 8'b0110, 1'b0, 1'b0);
    send(1'b1); send(1'b1); send(1'b1); send(1'b1);
    check_val("mask_match", int'(match_a), 1);
`endif

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 2) begin
        cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end else if (r < 7) begin
        pat = 8'($urandom); overlap = 1'($urandom); mask = 8'($urandom & $urandom);
        pat_len = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
        cyc(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));
      end else begin
        cyc(1'b1, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 19) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detect_p.md
SEQ_DETECT_P -- requirements
Module: seq_detect_p

Interface
REQ-001 SHALL have parameter PAT_W, default 8, maximum pattern length in bits (legal 2..32).
REQ-002 SHALL have parameter CNT_W, default 16, match-counter width.
REQ-003 SHALL have port i_clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  i_bit is accepted this cycle.
REQ-006 SHALL have port i_bit  input  1  serial data bit.
REQ-007 SHALL have port i_cfg_load  input  1  strobe; latch i_pat, i_pat_len and i_overlap.
REQ-008 SHALL have port i_pat  input  PAT_W  pattern; bit 0 = last bit received, bit len-1 = first bit received.
REQ-009 SHALL have port i_pat_len  input  $clog2(PAT_W+1)  active pattern length.
REQ-010 SHALL have port i_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port i_cnt_clr  input  1  clear match counter.
REQ-012 SHALL have port o_match  output  1  registered one-cycle match pulse.
REQ-013 SHALL have port o_match_cnt  output  CNT_W  saturating match count.
REQ-014 SHALL have port o_armed  output  1  high when state is not ST_IDLE.

Function
REQ-015 SHALL implement FSM states ST_IDLE (no pattern loaded), ST_FILL (fewer than len bits since last restart) and ST_HUNT (at least len bits held).
REQ-016 SHALL ignore i_valid in ST_IDLE.
REQ-017 SHALL, on i_cfg_load, latch the configuration, zero the history and fill count, and enter ST_FILL; with i_pat_len=0 it SHALL enter ST_IDLE.
REQ-018 SHALL clamp i_pat_len > PAT_W to PAT_W at load.
REQ-019 SHALL give i_cfg_load priority over i_valid in the same cycle; that bit is dropped.
REQ-020 SHALL, per accepted bit, shift the history left with the new bit in at bit 0, and increment the fill count, saturating at len; ST_FILL->ST_HUNT when the fill count reaches len.
REQ-021 SHALL detect a match when an accepted bit makes fill count = len and history[len-1:0] = pat[len-1:0].
REQ-022 SHALL assert o_match exactly in the cycle after the completing bit is accepted, for one cycle, low otherwise.
REQ-023 SHALL, in non-overlap mode, zero the fill count on match and return to ST_FILL; in overlap mode it SHALL stay in ST_HUNT.
REQ-024 SHALL increment o_match_cnt on the same edge that sets o_match, and saturate at 2^CNT_W-1.
REQ-025 SHALL give i_cnt_clr priority over a coincident increment, with result 0; o_match still pulses.
REQ-026 SHALL hold all state when i_valid=0; gaps between valid bits SHALL not break a sequence.

Reset
REQ-027 SHALL, with i_rst_n=0 at a clock edge: state ST_IDLE, history 0, fill 0, latched configuration 0, o_match 0, o_match_cnt 0, o_armed 0.
REQ-028 SHALL let reset override every other input, including mid-sequence and a coincident i_cfg_load.

Configuration
REQ-029 SHALL, when SEQ_DETECT_MASK_EN is defined, add input i_pat_mask [PAT_W] latched on i_cfg_load; mask bit 1 makes the corresponding pattern bit don't-care in the REQ-021 compare.
REQ-030 SHALL, without SEQ_DETECT_MASK_EN, have no i_pat_mask port and compare all len bits exactly.

Structure
REQ-031 SHALL place the state enum typedef (ST_IDLE=2'b00, ST_FILL=2'b01, ST_HUNT=2'b11) and the length-width localparam function in package seq_detect_pkg.
REQ-032 SHALL implement the saturating, clearable counter as sub-module seq_match_cnt, parameterised by CNT_W.

Verification
REQ-033 SHALL cover: load pat=3'b101, len=3, overlap=1; bits 1,0,1,0,1 -> o_match pulses after bit 3 and after bit 5; o_match_cnt=2.
REQ-034 SHALL cover: the same stream with overlap=0 -> single pulse after bit 3; o_match_cnt=1.
REQ-035 SHALL cover: len=8, pat=8'hA5, bits with i_valid gaps of 0..3 cycles -> one pulse, one cycle after the 8th valid bit.
REQ-036 SHALL cover: CNT_W=2, five matches -> count 1,2,3,3,3; i_cnt_clr coincident with the 6th match -> count 0 and o_match=1.
REQ-037 SHALL cover: i_cfg_load with i_valid on the completing bit -> no match and ST_FILL; i_rst_n=0 mid-sequence -> all outputs 0, ST_IDLE, and bits ignored until the next load.
REQ-038 SHALL cover, with SEQ_DETECT_MASK_EN: pat=4'b1001, mask=4'b0110, stream 1,1,1,1 -> match after 4th bit.
